// File: rtl/signal_query_arbiter.sv
// Purpose : shares one signal-history lookup engine between NUM_REQ trackers;
//           round-robin grant, timestamp -> cycles-back conversion, timeout.
// Latency : accept at T, recalculate from T+1, response at D+1 (data_valid at D >= T+2),
//           or at T+TIMEOUT_CYCLES+2 on timeout; minimum issue interval 4 cycles.
// Backpr. : req_ready is offered only in IDLE; a requester holds req_valid until
//           it sees req_ready. There is no backpressure on the response strobe.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   counter           global signed cycle counter
//   req_valid/_time   per-requester level request and absolute search timestamp
//                     (requester i at req_time[32i+31:32i])
//   req_ready         one-hot acceptance, combinational, IDLE only
//   resp_valid        one-hot one-cycle response strobe
//   resp_data         engine result, or all ones on timeout
//   resp_timeout      qualifies resp_valid: the query was abandoned
//   busy, grant_id    arbiter status, current/last granted requester
//   eng_*             engine query port (value_in, recalculate, data_valid, result)

module signal_query_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int RESULT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [31:0]          counter,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*32-1:0]       req_time,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [RESULT_WIDTH-1:0]     resp_data,
    output logic                        resp_timeout,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic [31:0]                 eng_value_in,
    output logic                        eng_recalculate,
    input  logic                        eng_data_valid,
    input  logic [RESULT_WIDTH-1:0]     eng_result
);

    localparam int GW  = $clog2(NUM_REQ);
    localparam int CW  = GW + 1;
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [GW-1:0]           rr_ptr, rr_nxt;
    logic [GW-1:0]           grant_nxt;
    logic signed [31:0]      latched_time, ltime_nxt;
    logic [31:0]             value_q, value_nxt;
    logic [WCW-1:0]          wait_cnt, wait_nxt;
    logic [RESULT_WIDTH-1:0] rdata_nxt;
    logic                    rto_nxt;

    // Rotating-priority search results.
    logic                    win_found;
    logic [GW-1:0]           win_idx;
    logic [31:0]             win_time;
    logic [31:0]             req_time_arr [NUM_REQ];
    logic [CW-1:0]           cand;

    // Cycles-back value for the engine.
    logic signed [31:0]      diff;
    logic [31:0]             issue_value;
    logic [GW-1:0]           next_ptr;

    // ------------------------------------------------------------------
    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_time_arr[i] = req_time[i*32 +: 32];
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, rr_ptr} + CW'(off);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[GW-1:0];
            end
        end
    end

    assign win_time = req_time_arr[win_idx];

    // A timestamp in the future means "now": clamp negative distances to 0.
    assign diff        = counter - latched_time;
    assign issue_value = diff[31] ? 32'd0 : diff;

    assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

    // ------------------------------------------------------------------
    // State register and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            latched_time <= '0;
            value_q      <= '0;
            wait_cnt     <= '0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            grant_id     <= grant_nxt;
            latched_time <= ltime_nxt;
            value_q      <= value_nxt;
            wait_cnt     <= wait_nxt;
            resp_data    <= rdata_nxt;
            resp_timeout <= rto_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt       = state;
        rr_nxt          = rr_ptr;
        grant_nxt       = grant_id;
        ltime_nxt       = latched_time;
        value_nxt       = value_q;
        wait_nxt        = wait_cnt;
        rdata_nxt       = resp_data;
        rto_nxt         = resp_timeout;
        req_ready       = '0;
        resp_valid      = '0;
        busy            = (state != S_IDLE);
        eng_recalculate = 1'b0;
        // Outside ISSUE the engine keeps seeing the value of the last query.
        eng_value_in    = value_q;

        case (state)
            S_IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    grant_nxt          = win_idx;
                    ltime_nxt          = win_time;
                    state_nxt          = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // The distance is driven straight through in ISSUE so the
                // engine sees it together with the first recalculate cycle;
                // it is also captured to hold it steady through WAIT.
                // eng_data_valid is deliberately not looked at here: it may
                // still belong to the previous query.
                eng_recalculate = 1'b1;
                eng_value_in    = issue_value;
                value_nxt       = issue_value;
                wait_nxt        = '0;
                state_nxt       = S_WAIT;
            end

            S_WAIT: begin
                eng_recalculate = 1'b1;
                wait_nxt        = wait_cnt + WCW'(1);
                if (eng_data_valid) begin
                    // A result arriving on the timeout cycle still wins.
                    rdata_nxt = eng_result;
                    rto_nxt   = 1'b0;
                    state_nxt = S_RESPOND;
                end else if (wait_cnt == WCW'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th WAIT cycle.
                    rdata_nxt = '1;
                    rto_nxt   = 1'b1;
                    state_nxt = S_RESPOND;
                end
            end

            S_RESPOND: begin
                resp_valid[grant_id] = 1'b1;
                rr_nxt               = next_ptr;
                state_nxt            = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
